// File: rtl/mem_preload_pkg.sv
// mem_preload_pkg: shared FSM state encoding and timing constants for the RAM preload controller
package mem_preload_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, DONE} state_t;
    localparam int DRAIN_CYCLES = 2;
endpackage

// File: rtl/mem_preload_ctrl_addr_gen.sv
// preload_addr_gen: latches base/length, counts words and produces the wrapped RAM address
module preload_addr_gen
    import mem_preload_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              restart,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W:0]   len_in,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              at_end
);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;

    assign addr   = ADDR_W'(({1'b0, base} + count) % DEPTH);
    assign last   = count == len;
    assign at_end = count + (ADDR_W+1)'(1) == len;

    // Base/length capture on start; the word counter rewinds for a second pass over the same range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base  <= '0;
            len   <= '0;
            count <= '0;
        end else if (start) begin
            base  <= base_in;
            len   <= len_in;
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (step) begin
            count <= count + (ADDR_W+1)'(1);
        end
    end
endmodule

// File: rtl/mem_preload_ctrl.sv
// mem_preload_ctrl: streams words into a RAM, holds the compute engine in reset until loaded; MEM_PRELOAD_VERIFY_EN adds an XOR read-back check
module mem_preload_ctrl
    import mem_preload_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wen_0,
    output logic [ADDR_W-1:0] waddr_0,
    output logic [DATA_W-1:0] wdata_0,
`ifdef MEM_PRELOAD_VERIFY_EN
    output logic [ADDR_W-1:0] raddr_0,
    output logic              ren_0,
    output logic              err,
    input  logic [DATA_W-1:0] rdata_0,
`endif
    output logic              dut_rst,
    output logic              busy,
    output logic              done
);
    state_t            state;
    logic [1:0]        drain_cnt;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              at_end;
    logic              beat;
    logic              step;

    assign in_ready = (state == LOAD) && !last;
    assign beat     = in_valid && in_ready;
    assign busy     = state != IDLE;

`ifdef MEM_PRELOAD_VERIFY_EN
    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] rchk;
    logic              rvalid;

    assign ren_0   = (state == VERIFY) && !last;
    assign raddr_0 = addr;
    assign step    = beat || ren_0;
`else
    assign step    = beat;
`endif

    preload_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (state == IDLE && go),
        .restart (state == DRAIN),
        .step    (step),
        .base_in (cfg_base),
        .len_in  (cfg_len),
        .addr    (addr),
        .last    (last),
        .at_end  (at_end)
    );

    // Control FSM with registered RAM write port, done pulse and downstream reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            wen_0     <= 1'b0;
            waddr_0   <= '0;
            wdata_0   <= '0;
            done      <= 1'b0;
            dut_rst   <= 1'b1;
`ifdef MEM_PRELOAD_VERIFY_EN
            chk       <= '0;
            rchk      <= '0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            wen_0 <= beat;
            if (beat) begin
                waddr_0 <= addr;
                wdata_0 <= in_data;
            end
            done <= state == DONE;
`ifdef MEM_PRELOAD_VERIFY_EN
            rvalid <= ren_0;
            if (beat) chk <= chk ^ in_data;
            if (rvalid) rchk <= rchk ^ rdata_0;
`endif
            case (state)
                IDLE: if (go) begin
                    dut_rst   <= 1'b1;
                    drain_cnt <= '0;
                    state     <= (cfg_len == '0) ? DONE : LOAD;
`ifdef MEM_PRELOAD_VERIFY_EN
                    chk       <= '0;
                    rchk      <= '0;
                    err       <= 1'b0;
`endif
                end
                LOAD: if (beat && at_end) state <= DRAIN;
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
`ifdef MEM_PRELOAD_VERIFY_EN
                        state <= VERIFY;
`else
                        state <= DONE;
`endif
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
`ifdef MEM_PRELOAD_VERIFY_EN
                VERIFY: if (last && rvalid) state <= DONE;
`endif
                DONE: begin
                    dut_rst <= 1'b0;
                    state   <= IDLE;
`ifdef MEM_PRELOAD_VERIFY_EN
                    err     <= chk != rchk;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_preload_ctrl.sv
// tb_mem_preload_ctrl: directed and randomized loads checked against a queue-based write model; MEM_PRELOAD_VERIFY_EN enables read-back tests
module tb_mem_preload_ctrl;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W:0]   cfg_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wen_0;
    logic [ADDR_W-1:0] waddr_0;
    logic [DATA_W-1:0] wdata_0;
    logic              dut_rst;
    logic              busy;
    logic              done;
    logic              corrupt = 1'b0;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PRELOAD_VERIFY_EN
    logic [ADDR_W-1:0] raddr_0;
    logic              ren_0;
    logic              err;
    logic [DATA_W-1:0] rdata_0;
`endif

    mem_preload_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wen_0    (wen_0),
        .waddr_0  (waddr_0),
        .wdata_0  (wdata_0),
`ifdef MEM_PRELOAD_VERIFY_EN
        .raddr_0  (raddr_0),
        .ren_0    (ren_0),
        .err      (err),
        .rdata_0  (rdata_0),
`endif
        .dut_rst  (dut_rst),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // RAM model: write port plus optional registered read port with a stuck bit at address 3
    always @(posedge clk) if (wen_0) mem[waddr_0] <= wdata_0;
`ifdef MEM_PRELOAD_VERIFY_EN
    always @(posedge clk) if (ren_0) rdata_0 <= mem[raddr_0] ^ ((corrupt && raddr_0 == 5'd3) ? 32'h1 : 32'h0);
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    int done_at;
    int dones;
    int sent;
    bit ir_seen;
    bit rst_ok;
    logic dut_rst_at_done;
    logic err_at_done;
    logic [DATA_W-1:0] dq [64];
    logic [DATA_W-1:0] wq_a [$];
    logic [DATA_W-1:0] wq_d [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (wen_0) begin
            wq_a.push_back(32'(waddr_0));
            wq_d.push_back(wdata_0);
        end
        if (in_ready) ir_seen = 1'b1;
        if (done) begin
            dones++;
            if (done_at < 0) begin
                done_at = cyc;
                dut_rst_at_done = dut_rst;
`ifdef MEM_PRELOAD_VERIFY_EN
                err_at_done = err;
`else
                err_at_done = 1'b0;
`endif
            end
        end
    endtask

    // One complete load: mode 0 back-to-back, 1 valid every other cycle, 2 random valid
    task automatic run(input int base, input int len, input int mode);
        bit exp_err;
        wq_a.delete();
        wq_d.delete();
        cyc = 0; done_at = -1; dones = 0; sent = 0; ir_seen = 1'b0; rst_ok = 1'b1;
        exp_err = 1'b0;
        for (int i = 0; i < len; i++) if ((base + i) % DEPTH == 3) exp_err = corrupt;
        go = 1'b1;
        cfg_base = ADDR_W'(base);
        cfg_len = (ADDR_W+1)'(len);
        step();
        go = 1'b0;
        chk("dut_rst_after_go", 32'(dut_rst), 1);
        chk("busy_after_go", 32'(busy), 1);
        while (done_at < 0 && cyc < 600) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            in_data = (sent < len) ? dq[sent] : $urandom;
            if (in_valid && in_ready) sent++;
            if (!dut_rst) rst_ok = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("n_writes", 32'(wq_a.size()), 32'(len));
        for (int i = 0; i < len && i < wq_a.size(); i++) begin
            chk("waddr", wq_a[i], 32'((base + i) % DEPTH));
            chk("wdata", wq_d[i], dq[i]);
        end
        chk("done_count", 32'(dones), 1);
        chk("dut_rst_held", 32'(rst_ok), 1);
        chk("dut_rst_at_done", 32'(dut_rst_at_done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("dut_rst_low_after", 32'(dut_rst), 0);
        if (len == 0) begin
            chk("len0_done_latency", 32'(done_at), 2);
            chk("len0_no_ready", 32'(ir_seen), 0);
        end else if (mode == 0) begin
`ifdef MEM_PRELOAD_VERIFY_EN
            chk("done_latency", 32'(done_at), 32'(2 * len + 5));
`else
            chk("done_latency", 32'(done_at), 32'(len + 4));
`endif
        end
`ifdef MEM_PRELOAD_VERIFY_EN
        chk("err_at_done", 32'(err_at_done), 32'(exp_err));
`endif
    endtask

    initial begin
        logic [DATA_W-1:0] d12 [12];
        d12 = '{32'd6, 32'd1, 32'd2, 32'd3, 32'd7, 32'd5, 32'd5, 32'd2, 32'd9, 32'd9, 32'd3, 32'd7};
        rst = 1'b1; go = 1'b0; cfg_base = '0; cfg_len = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", 32'(wen_0), 0);
        chk("rst_waddr", 32'(waddr_0), 0);
        chk("rst_wdata", wdata_0, 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dut_rst", 32'(dut_rst), 1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) dq[i] = d12[i];
        run(0, 12, 0);

        for (int i = 0; i < 4; i++) dq[i] = 32'(10 + i);
        run(30, 4, 0);

        run(0, 0, 0);

        for (int i = 0; i < 3; i++) dq[i] = $urandom;
        run(5, 3, 1);

        // Reset in the middle of a 5-word load
        for (int i = 0; i < 5; i++) dq[i] = $urandom;
        wq_a.delete();
        wq_d.delete();
        sent = 0;
        go = 1'b1; cfg_base = 5'd7; cfg_len = 6'd5;
        step();
        go = 1'b0;
        for (int k = 0; k < 20 && sent < 2; k++) begin
            in_valid = 1'b1;
            in_data = dq[sent];
            if (in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("abort_wen", 32'(wen_0), 0);
        chk("abort_waddr", 32'(waddr_0), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_dut_rst", 32'(dut_rst), 1);
        in_valid = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        chk("abort_writes", 32'(wq_a.size()), 2);
        chk("abort_idle_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) dq[i] = $urandom;
        run(9, 5, 0);

`ifdef MEM_PRELOAD_VERIFY_EN
        for (int i = 0; i < 8; i++) dq[i] = $urandom;
        corrupt = 1'b1;
        run(0, 8, 0);
        corrupt = 1'b0;
        run(0, 8, 0);
`endif

        for (int t = 0; t < 6; t++) begin
            int b;
            int l;
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, DEPTH);
            for (int i = 0; i < l; i++) dq[i] = $urandom;
            run(b, l, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_preload_ctrl.md
MEM_PRELOAD_CTRL -- requirements
Module: mem_preload_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter DEPTH, default 32, RAM words; equals 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port go, input, 1, start-load request.
REQ-007 SHALL have port cfg_base, input, ADDR_W, first RAM address; sampled on go accept.
REQ-008 SHALL have port cfg_len, input, ADDR_W+1, word count 0..DEPTH; sampled on go accept.
REQ-009 SHALL have port in_valid, input, 1, stream word valid.
REQ-010 SHALL have port in_data, input, DATA_W, stream word.
REQ-011 SHALL have port in_ready, output, 1, stream word accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port wen_0, output, 1, RAM write enable.
REQ-013 SHALL have port waddr_0, output, ADDR_W, RAM write address.
REQ-014 SHALL have port wdata_0, output, DATA_W, RAM write data.
REQ-015 SHALL have port dut_rst, output, 1, reset held on the downstream compute engine until load completes.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DRAIN, VERIFY (macro only), DONE.
REQ-019 SHALL, in IDLE with go=1, latch cfg_base/cfg_len, clear the word counter, and move to LOAD, or to DONE when cfg_len=0.
REQ-020 SHALL drive in_ready=1 only in LOAD while the word counter is below the latched cfg_len.
REQ-021 SHALL register wen_0=1 with waddr_0=(base+count) mod DEPTH and wdata_0=in_data in the cycle after each accepted beat; wen_0=0 otherwise.
REQ-022 SHALL wrap addresses modulo DEPTH (base 30, len 4 -> 30,31,0,1).
REQ-023 SHALL, on the accept of beat cfg_len, go LOAD->DRAIN; DRAIN SHALL last 2 cycles to cover the RAM one-cycle write delay, then go to VERIFY or DONE.
REQ-024 SHALL, in DONE, pulse done=1 for exactly one cycle, drop dut_rst to 0, and return to IDLE.
REQ-025 SHALL hold dut_rst=0 after DONE until the next go accept; dut_rst SHALL rise the cycle after go is accepted.
REQ-026 SHALL ignore go outside IDLE; in_valid without in_ready SHALL have no effect.
REQ-027 SHALL stall indefinitely with in_valid=0 in LOAD (no timeout), keeping wen_0=0.

Reset
REQ-028 SHALL, on rst, set IDLE, wen_0=0, waddr_0=0, wdata_0=0, in_ready=0, busy=0, done=0, dut_rst=1, counters=0, err=0 (when present).
REQ-029 SHALL abort immediately on rst mid-LOAD; any delayed write already issued to RAM SHALL NOT be reissued.

Configuration
REQ-030 SHALL compile the read-back check when MEM_PRELOAD_VERIFY_EN is defined: add outputs raddr_0 (ADDR_W), ren_0 (1), err (1), and input rdata_0 (DATA_W).
REQ-031 SHALL, with the macro defined, keep a running XOR of written words; in VERIFY, read back the same addresses one per cycle (registered read, data the following cycle), XOR them, and set err=1 at DONE on mismatch; err is held until the next go.
REQ-032 SHALL, without the macro, omit those ports, skip VERIFY (DRAIN->DONE), and have no checksum logic.

Structure
REQ-033 SHALL place the FSM state enum and the DRAIN_CYCLES=2 constant in shared package mem_preload_pkg.
REQ-034 SHALL use one sub-module, preload_addr_gen (base latch, counter, modulo-DEPTH address, last flag).

Verification
REQ-035 SHALL test base 0, len 12, words 6,1,2,3,7,5,5,2,9,9,3,7 back-to-back -> wen_0 pulses on addresses 0..11 with those data, done once, dut_rst falls on the done cycle.
REQ-036 SHALL test base 30, len 4, data 10..13 -> writes to 30,31,0,1, then done.
REQ-037 SHALL test len 0 -> no wen_0, done pulse 2 cycles after go, in_ready never high.
REQ-038 SHALL test in_valid toggled every other cycle, len 3 -> exactly 3 writes, in-order, no duplicates.
REQ-039 SHALL test rst asserted after beat 2 of 5 -> outputs at reset values immediately, no further writes, a new go restarts cleanly.
REQ-040 SHALL test, with MEM_PRELOAD_VERIFY_EN, a RAM model corrupting address 3 -> err=1 at done; with an intact RAM -> err=0.
